// File: rtl/timer_pkg.sv
// Shared types, constants and BCD/7-segment helpers for the multimode timer.
package timer_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    localparam logic [2:0] DIG_H1 = 3'd0;
    localparam logic [2:0] DIG_H2 = 3'd1;
    localparam logic [2:0] DIG_M1 = 3'd2;
    localparam logic [2:0] DIG_M2 = 3'd3;
    localparam logic [2:0] DIG_S1 = 3'd4;
    localparam logic [2:0] DIG_S2 = 3'd5;

    // Segment order {a,b,c,d,e,f,g}, active-high.
    function automatic logic [6:0] seg7(input bcd_t d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Two-digit BCD step; bit 8 of the result is the carry/borrow into the next pair.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last) return 9'h100;
        if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
        return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [8:0] bcd_dec(input logic [7:0] v, input logic [7:0] last);
        if (v == 8'h00) return {1'b1, last};
        if (v[3:0] == 4'd0) return {1'b0, v[7:4] - 4'd1, 4'd9};
        return {1'b0, v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle enable every DIV clocks.
module tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == W'(DIV - 1));
        cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/multimode_timer_scan.sv
// BCD H:M:S up/down timer with preset load, lap freeze, countdown expiry and
// a multiplexed 7-segment display driver, all on one clock via enables.
module multimode_timer_scan
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 10_000_000,
    parameter int unsigned SCAN_HZ    = 1000,
    parameter int unsigned FAST_DIV   = 100,
    parameter int unsigned HOUR_MODE  = 24,
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SEG_INV    = 0
) (
    input  logic        MHz,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        Speed,
    input  logic        Mode,
    input  logic        Load,
    input  logic [23:0] LdVal,
    input  logic        Lap,
    output logic        Expired,
    output logic        LoadErr,
    output logic [2:0]  DE,
    output logic [6:0]  seg
);

    localparam logic [7:0] H_LAST   = 8'(((HOUR_MODE - 1) / 10) * 16 + (HOUR_MODE - 1) % 10);
    localparam logic [6:0] SEG_MASK = (SEG_INV != 0) ? 7'h7F : 7'h00;
    localparam logic [2:0] DE_LAST  = 3'(NUM_DIGITS - 1);
    // A 4-digit display starts at M1, so DE is offset into the H1..S2 digit order.
    localparam logic [2:0] DIG_OFS  = 3'(6 - NUM_DIGITS);

    logic sec_tk, fast_tk, scan_tk, cnt_tk;

    tick_gen #(.DIV(CLK_HZ)) u_sec_tick (
        .clk_i  (MHz),
        .rst_i  (Reset),
        .tick_o (sec_tk)
    );

    tick_gen #(.DIV(CLK_HZ / FAST_DIV)) u_fast_tick (
        .clk_i  (MHz),
        .rst_i  (Reset),
        .tick_o (fast_tk)
    );

    tick_gen #(.DIV(CLK_HZ / SCAN_HZ)) u_scan_tick (
        .clk_i  (MHz),
        .rst_i  (Reset),
        .tick_o (scan_tk)
    );

    assign cnt_tk = Speed ? sec_tk : fast_tk;

    logic [23:0] dig_q, dig_d, snap_q, snap_d, disp;
    logic        lap_q, lap_d, expired_q, expired_d, load_err_q, load_err_d;
    logic [2:0]  de_q, de_d, dig_idx;
    logic [6:0]  seg_q, seg_d;
    bcd_t        cur;
    logic [8:0]  s_up, m_up, h_up, s_dn, m_dn, h_dn;
    logic        nib_ok, ld_ok;

    assign s_up = bcd_inc(dig_q[7:0], 8'h59);
    assign m_up = bcd_inc(dig_q[15:8], 8'h59);
    assign h_up = bcd_inc(dig_q[23:16], H_LAST);
    assign s_dn = bcd_dec(dig_q[7:0], 8'h59);
    assign m_dn = bcd_dec(dig_q[15:8], 8'h59);
    assign h_dn = bcd_dec(dig_q[23:16], H_LAST);

    always_comb begin
        nib_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (LdVal[4*i +: 4] > 4'd9) nib_ok = 1'b0;
        end
    end

    // With every nibble <= 9, plain binary compare orders BCD pairs correctly.
    assign ld_ok = nib_ok && (LdVal[7:0] <= 8'h59) && (LdVal[15:8] <= 8'h59) &&
                   (LdVal[23:16] <= H_LAST);

    always_comb begin
        dig_d      = dig_q;
        expired_d  = 1'b0;
        load_err_d = 1'b0;
        if (Load) begin
            if (ld_ok) dig_d = LdVal;
            else       load_err_d = 1'b1;
        end else if (cnt_tk && !Enable) begin
            if (Mode == MODE_UP) begin
                dig_d[7:0] = s_up[7:0];
                if (s_up[8])              dig_d[15:8]  = m_up[7:0];
                if (s_up[8] && m_up[8])   dig_d[23:16] = h_up[7:0];
            end else if (dig_q != 24'h000000) begin
                dig_d[7:0] = s_dn[7:0];
                if (s_dn[8])              dig_d[15:8]  = m_dn[7:0];
                if (s_dn[8] && m_dn[8])   dig_d[23:16] = h_dn[7:0];
                expired_d = (dig_q == 24'h000001);
            end
        end
    end

    // Snapshot shows only once captured; on the rising cycle live digits equal it anyway.
    always_comb begin
        lap_d  = Lap;
        snap_d = (Lap && !lap_q) ? dig_q : snap_q;
        disp   = (Lap && lap_q) ? snap_q : dig_q;
        de_d   = de_q;
        if (scan_tk) de_d = (de_q == DE_LAST) ? 3'd0 : de_q + 3'd1;
        dig_idx = de_d + DIG_OFS;
        case (dig_idx)
            DIG_H1:  cur = disp[23:20];
            DIG_H2:  cur = disp[19:16];
            DIG_M1:  cur = disp[15:12];
            DIG_M2:  cur = disp[11:8];
            DIG_S1:  cur = disp[7:4];
            DIG_S2:  cur = disp[3:0];
            default: cur = 4'd0;
        endcase
        seg_d = seg7(cur) ^ SEG_MASK;
    end

    always_ff @(posedge MHz) begin
        if (Reset) begin
            dig_q      <= '0;
            snap_q     <= '0;
            lap_q      <= 1'b0;
            de_q       <= 3'd0;
            seg_q      <= 7'b1111110 ^ SEG_MASK;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            dig_q      <= dig_d;
            snap_q     <= snap_d;
            lap_q      <= lap_d;
            de_q       <= de_d;
            seg_q      <= seg_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    assign Expired = expired_q;
    assign LoadErr = load_err_q;
    assign DE      = de_q;
    assign seg     = seg_q;

endmodule

// File: tb/tb_multimode_timer_scan.sv
// Scoreboard bench: a 24h/6-digit and a 12h/4-digit timer driven in parallel.
module tb_multimode_timer_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset, Enable, Speed, Mode, Load, Lap;
    logic [23:0] LdVal;
    logic        exp_a, err_a, exp_b, err_b;
    logic [2:0]  de_a, de_b;
    logic [6:0]  seg_a, seg_b;

    int unsigned cyc;
    int          n_chk = 0;
    int          n_err = 0;

    logic [23:0] frame_a_q[$];
    logic [15:0] frame_b_q[$];
    int          ev_a_q[$];  // 1 = Expired pulse, 2 = LoadErr pulse
    int          ev_b_q[$];

    multimode_timer_scan #(
        .CLK_HZ(1000), .SCAN_HZ(100), .FAST_DIV(10), .HOUR_MODE(24), .NUM_DIGITS(6), .SEG_INV(0)
    ) u_dut_a (
        .MHz(clk), .Reset(Reset), .Enable(Enable), .Speed(Speed), .Mode(Mode), .Load(Load),
        .LdVal(LdVal), .Lap(Lap), .Expired(exp_a), .LoadErr(err_a), .DE(de_a), .seg(seg_a)
    );

    multimode_timer_scan #(
        .CLK_HZ(1000), .SCAN_HZ(100), .FAST_DIV(10), .HOUR_MODE(12), .NUM_DIGITS(4), .SEG_INV(0)
    ) u_dut_b (
        .MHz(clk), .Reset(Reset), .Enable(Enable), .Speed(Speed), .Mode(Mode), .Load(Load),
        .LdVal(LdVal), .Lap(Lap), .Expired(exp_b), .LoadErr(err_b), .DE(de_b), .seg(seg_b)
    );

    // Edges since reset release; fast ticks land on edges where cyc becomes a multiple of 100.
    always @(posedge clk) cyc <= Reset ? 0 : cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at t=%0t", name, got, want, $time);
        end
    endtask

    function automatic logic [3:0] seg_to_bcd(input logic [6:0] s);
        case (s)
            7'h7E:   return 4'd0;
            7'h30:   return 4'd1;
            7'h6D:   return 4'd2;
            7'h79:   return 4'd3;
            7'h33:   return 4'd4;
            7'h5B:   return 4'd5;
            7'h5F:   return 4'd6;
            7'h70:   return 4'd7;
            7'h7F:   return 4'd8;
            7'h7B:   return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    initial begin : mon_a
        logic [2:0]  prev;
        logic [5:0]  seen;
        logic [23:0] got;
        prev = 3'd0;
        seen = '0;
        got  = '0;
        forever begin
            @(negedge clk);
            if (exp_a || err_a) begin
                if (ev_a_q.size() == 0) check("pulse_a_unexpected", {30'd0, err_a, exp_a}, 32'd0);
                else check("pulse_a", {30'd0, err_a, exp_a}, 32'(ev_a_q.pop_front()));
            end
            if (Reset) begin
                prev = de_a;
                seen = '0;
            end else if (de_a != prev) begin
                check("scan_a", 32'(de_a), (prev == 3'd5) ? 32'd0 : 32'(prev) + 32'd1);
                prev = de_a;
                if (frame_a_q.size() != 0) begin
                    got[4*(5 - int'(de_a)) +: 4] = seg_to_bcd(seg_a);
                    seen[de_a] = 1'b1;
                    if (&seen) begin
                        check("frame_a", 32'(got), 32'(frame_a_q.pop_front()));
                        seen = '0;
                    end
                end else begin
                    seen = '0;
                end
            end
        end
    end

    initial begin : mon_b
        logic [2:0]  prev;
        logic [3:0]  seen;
        logic [15:0] got;
        prev = 3'd0;
        seen = '0;
        got  = '0;
        forever begin
            @(negedge clk);
            if (exp_b || err_b) begin
                if (ev_b_q.size() == 0) check("pulse_b_unexpected", {30'd0, err_b, exp_b}, 32'd0);
                else check("pulse_b", {30'd0, err_b, exp_b}, 32'(ev_b_q.pop_front()));
            end
            if (Reset) begin
                prev = de_b;
                seen = '0;
            end else if (de_b != prev) begin
                check("scan_b", 32'(de_b), (prev == 3'd3) ? 32'd0 : 32'(prev) + 32'd1);
                prev = de_b;
                if (frame_b_q.size() != 0) begin
                    got[4*(3 - int'(de_b)) +: 4] = seg_to_bcd(seg_b);
                    seen[de_b[1:0]] = 1'b1;
                    if (&seen) begin
                        check("frame_b", 32'(got), 32'(frame_b_q.pop_front()));
                        seen = '0;
                    end
                end else begin
                    seen = '0;
                end
            end
        end
    end

    task automatic window(input int n);
        Enable = 1'b0;
        repeat (n) @(negedge clk);
        Enable = 1'b1;
    endtask

    task automatic do_load(input logic [23:0] v);
        LdVal = v;
        Load  = 1'b1;
        @(negedge clk);
        Load  = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_frames(input logic [23:0] a, input logic [15:0] b);
        repeat (2) @(negedge clk);
        frame_a_q.push_back(a);
        frame_b_q.push_back(b);
    endtask

    task automatic wait_frames();
        int k = 0;
        while ((frame_a_q.size() + frame_b_q.size()) != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("frame_timeout", 32'(frame_a_q.size() + frame_b_q.size()), 32'd0);
        frame_a_q.delete();
        frame_b_q.delete();
    endtask

    task automatic drain_events();
        repeat (3) @(negedge clk);
        check("events_missing", 32'(ev_a_q.size() + ev_b_q.size()), 32'd0);
        ev_a_q.delete();
        ev_b_q.delete();
    endtask

    initial begin : stim
        Reset = 1'b1; Enable = 1'b1; Speed = 1'b1; Mode = 1'b0;
        Load = 1'b0; Lap = 1'b0; LdVal = '0;
        repeat (3) @(negedge clk);
        check("rst_de_a", 32'(de_a), 32'd0);
        check("rst_seg_a", 32'(seg_a), 32'h7E);
        check("rst_exp_a", 32'(exp_a), 32'd0);
        check("rst_err_a", 32'(err_a), 32'd0);
        check("rst_de_b", 32'(de_b), 32'd0);
        check("rst_seg_b", 32'(seg_b), 32'h7E);
        check("rst_exp_b", 32'(exp_b), 32'd0);
        check("rst_err_b", 32'(err_b), 32'd0);
        Reset = 1'b0;
        expect_frames(24'h000000, 16'h0000); wait_frames();

        // Day wrap on the 24h unit; hour 23 is out of range for the 12h unit.
        ev_b_q.push_back(2);
        do_load(24'h235959); drain_events();
        expect_frames(24'h235959, 16'h0000); wait_frames();
        window(1000);
        expect_frames(24'h000000, 16'h0001); wait_frames();

        do_load(24'h115959);
        expect_frames(24'h115959, 16'h5959); wait_frames();
        window(1000);
        expect_frames(24'h120000, 16'h0000); wait_frames();
        // 12h unit must sit at 00:00:00 (holds); a bad hour wrap would show 59:59.
        Mode = 1'b1;
        window(1000);
        expect_frames(24'h115959, 16'h0000); wait_frames();
        drain_events();

        // Countdown expiry, then a tick at zero with no pulse.
        Speed = 1'b0;
        do_load(24'h000002);
        window(100);
        expect_frames(24'h000001, 16'h0001); wait_frames();
        ev_a_q.push_back(1); ev_b_q.push_back(1);
        window(100); drain_events();
        expect_frames(24'h000000, 16'h0000); wait_frames();
        window(100); drain_events();
        expect_frames(24'h000000, 16'h0000); wait_frames();

        // Rejected loads: minutes 70, then a non-BCD nibble.
        ev_a_q.push_back(2); ev_b_q.push_back(2);
        do_load(24'h007000);
        ev_a_q.push_back(2); ev_b_q.push_back(2);
        do_load(24'h00000A);
        drain_events();
        expect_frames(24'h000000, 16'h0000); wait_frames();

        // Load on the very edge a fast tick is consumed.
        Mode = 1'b0;
        while (((cyc + 1) % 100) != 0) @(negedge clk);
        LdVal = 24'h000010; Load = 1'b1; Enable = 1'b0;
        @(negedge clk);
        Load = 1'b0; Enable = 1'b1;
        expect_frames(24'h000010, 16'h0010); wait_frames();

        Lap = 1'b1;
        expect_frames(24'h000010, 16'h0010);
        window(500);
        wait_frames();
        Lap = 1'b0;
        expect_frames(24'h000015, 16'h0015); wait_frames();

        // Lap held across reset keeps showing the cleared snapshot.
        Lap = 1'b1; Reset = 1'b1;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        ev_b_q.push_back(2);
        do_load(24'h123456); drain_events();
        expect_frames(24'h000000, 16'h0000); wait_frames();
        Lap = 1'b0;
        expect_frames(24'h123456, 16'h0000); wait_frames();
        drain_events();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : guard
        #2_000_000;
        $display("FAIL global_timeout: got running, want finished (errors=%0d)", n_err);
        $fatal(1, "timeout");
    end

endmodule
